// File: rtl/ahb_sram_pkg.sv
// Shared AHB encodings and byte-lane decode for the SRAM controller.
package ahb_sram_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    // Byte enables for an access; anything wider than a halfword is a full word.
    // Misaligned halfwords simply use the half selected by addr_lo[1].
    function automatic logic [3:0] lane_ben(input logic [2:0] hsize, input logic [1:0] addr_lo);
        logic [3:0] ben;
        case (hsize)
            HSIZE_BYTE: ben = 4'b0001 << addr_lo;
            HSIZE_HALF: ben = addr_lo[1] ? 4'b1100 : 4'b0011;
            default:    ben = 4'b1111;
        endcase
        return ben;
    endfunction

endpackage

// File: rtl/ahb_sram_wbuf.sv
// One-entry write buffer: owns the SRAM port arbitration (reads first, then
// buffered write commit) and merges buffered bytes into read data.
module ahb_sram_wbuf
    import ahb_sram_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_i,
    input  logic              wr_i,
    input  logic              hready_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [3:0]        ben_i,
    input  logic [31:0]       hwdata_i,
    input  logic [31:0]       sram_dout_i,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic [31:0]       sram_din_o,
    output logic [3:0]        sram_ben_o,
    output logic              sram_wren_o,
    output logic [31:0]       rdata_o
);

    logic              pend_q, pend_d;
    logic              dph_q, dph_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        ben_q, ben_d;
    logic [31:0]       data_q, data_d;
    logic              hit_q, hit_d;
    logic [3:0]        hit_ben_q, hit_ben_d;
    logic              commit;

    // The buffered write may use the port only when no read claims it.
    assign commit = pend_q && !rd_i;

    // SRAM port mux: read, else commit, else idle on the buffer contents.
    always_comb begin
        sram_addr_o = addr_q;
        sram_ben_o  = 4'b0000;
        sram_wren_o = 1'b0;
        sram_din_o  = data_q;
        if (rd_i) begin
            sram_addr_o = addr_i;
            sram_ben_o  = 4'b1111;
        end else if (pend_q) begin
            sram_ben_o  = ben_q;
            sram_wren_o = 1'b1;
            // Earliest commit lands in the data phase itself, before capture.
            sram_din_o  = dph_q ? hwdata_i : data_q;
        end
    end

    // Buffer next state: data capture, new write load, commit retire, hit record.
    always_comb begin
        pend_d    = pend_q;
        dph_d     = dph_q;
        addr_d    = addr_q;
        ben_d     = ben_q;
        data_d    = data_q;
        hit_d     = hit_q;
        hit_ben_d = hit_ben_q;
        if (dph_q && hready_i) begin
            data_d = hwdata_i;
            dph_d  = 1'b0;
        end
        // A write address phase never reads, so any older entry commits this cycle.
        if (wr_i) begin
            addr_d = addr_i;
            ben_d  = ben_i;
            pend_d = 1'b1;
            dph_d  = 1'b1;
        end else if (commit) begin
            pend_d = 1'b0;
        end
        if (rd_i) begin
            hit_d     = pend_q && (addr_q == addr_i);
            hit_ben_d = ben_q;
        end
    end

    // Buffer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q    <= 1'b0;
            dph_q     <= 1'b0;
            addr_q    <= '0;
            ben_q     <= 4'b0000;
            data_q    <= 32'h0;
            hit_q     <= 1'b0;
            hit_ben_q <= 4'b0000;
        end else begin
            pend_q    <= pend_d;
            dph_q     <= dph_d;
            addr_q    <= addr_d;
            ben_q     <= ben_d;
            data_q    <= data_d;
            hit_q     <= hit_d;
            hit_ben_q <= hit_ben_d;
        end
    end

    // Per-lane forwarding of still-uncommitted bytes over stale SRAM data.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign rdata_o[8*gi +: 8] = (hit_q && hit_ben_q[gi]) ? data_q[8*gi +: 8]
                                                                 : sram_dout_i[8*gi +: 8];
        end
    endgenerate

endmodule

// File: rtl/ahb_sram_ctrl.sv
// Zero-wait-state AHB-Lite slave in front of a single-port synchronous SRAM.
module ahb_sram_ctrl
    import ahb_sram_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hsel,
    input  logic [ADDR_W+1:0] haddr,
    input  logic [1:0]        htrans,
    input  logic              hwrite,
    input  logic [2:0]        hsize,
    input  logic [31:0]       hwdata,
    input  logic              hready,
    output logic              hreadyout,
    output logic              hresp,
    output logic [31:0]       hrdata,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_din,
    output logic [3:0]        sram_ben,
    output logic              sram_wren,
    input  logic [31:0]       sram_dout
);

    logic        acc;
    logic        rd;
    logic        wr;
    logic        rd_dph_q, rd_dph_d;
    logic [31:0] merged_rdata;
    logic        unused_htrans0;

    // NONSEQ and SEQ are treated alike; only htrans[1] matters.
    assign acc            = hsel && hready && htrans[1];
    assign rd             = acc && !hwrite;
    assign wr             = acc && hwrite;
    assign unused_htrans0 = htrans[0];

    assign hreadyout = 1'b1;
    assign hresp     = 1'b0;

    // Read data phase follows every read address phase by exactly one cycle.
    always_comb begin
        rd_dph_d = rd;
    end

    // Read data-phase flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_dph_q <= 1'b0;
        end else begin
            rd_dph_q <= rd_dph_d;
        end
    end

    ahb_sram_wbuf #(
        .ADDR_W(ADDR_W)
    ) u_wbuf (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_i        (rd),
        .wr_i        (wr),
        .hready_i    (hready),
        .addr_i      (haddr[ADDR_W+1:2]),
        .ben_i       (lane_ben(hsize, haddr[1:0])),
        .hwdata_i    (hwdata),
        .sram_dout_i (sram_dout),
        .sram_addr_o (sram_addr),
        .sram_din_o  (sram_din),
        .sram_ben_o  (sram_ben),
        .sram_wren_o (sram_wren),
        .rdata_o     (merged_rdata)
    );

    // Bus read data is driven only in a read data phase.
    assign hrdata = rd_dph_q ? merged_rdata : 32'h0;

endmodule

// File: tb/tb_ahb_sram_ctrl.sv
// Bench for ahb_sram_ctrl: directed scenarios plus random bus traffic checked
// against a byte-addressed memory model updated in AHB program order.
module tb_ahb_sram_ctrl;
    import ahb_sram_pkg::*;

    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              hsel = 1'b0;
    logic [ADDR_W+1:0] haddr = '0;
    logic [1:0]        htrans = HTRANS_IDLE;
    logic              hwrite = 1'b0;
    logic [2:0]        hsize = HSIZE_WORD;
    logic [31:0]       hwdata = 32'h0;
    logic              hready = 1'b1;
    logic              hreadyout;
    logic              hresp;
    logic [31:0]       hrdata;
    logic [ADDR_W-1:0] sram_addr;
    logic [31:0]       sram_din;
    logic [3:0]        sram_ben;
    logic              sram_wren;
    logic [31:0]       sram_dout = 32'h0;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural SRAM (stands in for ram32x256).
    logic [31:0] mem [256] = '{default: 32'h0};
    // Reference model: memory as the bus master sees it, in program order.
    logic [7:0]  ref_mem [1024] = '{default: 8'h0};

    logic        exp_rd_v = 1'b0;
    logic [31:0] exp_rd = 32'h0;
    logic        dph_wr = 1'b0;
    logic [31:0] dph_wdata = 32'h0;

    always #5 clk = ~clk;

    ahb_sram_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .hsel      (hsel),
        .haddr     (haddr),
        .htrans    (htrans),
        .hwrite    (hwrite),
        .hsize     (hsize),
        .hwdata    (hwdata),
        .hready    (hready),
        .hreadyout (hreadyout),
        .hresp     (hresp),
        .hrdata    (hrdata),
        .sram_addr (sram_addr),
        .sram_din  (sram_din),
        .sram_ben  (sram_ben),
        .sram_wren (sram_wren),
        .sram_dout (sram_dout)
    );

    function automatic logic [31:0] merge_bytes(input logic [31:0] old, input logic [31:0] din,
                                                input logic [3:0] ben);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (ben[b]) r[8*b +: 8] = din[8*b +: 8];
        return r;
    endfunction

    // SRAM: synchronous write, registered read.
    always @(posedge clk) begin
        if (sram_wren) mem[sram_addr] <= merge_bytes(mem[sram_addr], sram_din, sram_ben);
        sram_dout <= mem[sram_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %08h, expected %08h", tag, obs, exp);
    endtask

    function automatic logic [31:0] ref_word(input int byte_addr);
        int base;
        base = (byte_addr / 4) * 4;
        return {ref_mem[base+3], ref_mem[base+2], ref_mem[base+1], ref_mem[base]};
    endfunction

    // A write of 1, 2 or 4 bytes at the naturally aligned block containing addr;
    // byte i of memory always travels on lane i%4 of the data bus.
    task automatic ref_write(input int byte_addr, input logic [2:0] size, input logic [31:0] wdata);
        int n;
        int start;
        n = (size == HSIZE_BYTE) ? 1 : (size == HSIZE_HALF) ? 2 : 4;
        start = (byte_addr / n) * n;
        for (int i = start; i < start + n; i++) ref_mem[i] = wdata[8*(i%4) +: 8];
    endtask

    // One bus cycle: check the data phase that just ended, then drive the next inputs.
    task automatic bus(input logic sel, input logic [1:0] trans, input logic wr,
                       input logic [2:0] size, input int addr, input logic [31:0] wdata,
                       input logic rdy);
        logic acc;
        @(negedge clk);
        if (exp_rd_v) check("hrdata", hrdata, exp_rd);
        else          check("hrdata_zero", hrdata, 32'h0);
        check("resp", {30'h0, hreadyout, hresp}, 32'h2);
        hsel   = sel;
        htrans = trans;
        hwrite = wr;
        hsize  = size;
        haddr  = addr[ADDR_W+1:0];
        hready = rdy;
        hwdata = dph_wr ? dph_wdata : $urandom();
        acc = sel && rdy && trans[1];
        exp_rd_v = acc && !wr;
        if (exp_rd_v) exp_rd = ref_word(addr);
        if (acc && wr) ref_write(addr, size, wdata);
        if (rdy) begin
            dph_wr    = acc && wr;
            dph_wdata = wdata;
        end
        if (acc) $display("%0t %s addr=%03h size=%0d data=%08h", $time, wr ? "WR" : "RD",
                          addr[ADDR_W+1:0], size, wr ? wdata : exp_rd);
    endtask

    task automatic idle();
        bus(1'b0, HTRANS_IDLE, 1'b0, HSIZE_WORD, 0, 32'h0, 1'b1);
    endtask

    task automatic wr_op(input int addr, input logic [2:0] size, input logic [31:0] d);
        bus(1'b1, HTRANS_NONSEQ, 1'b1, size, addr, d, 1'b1);
    endtask

    task automatic rd_op(input int addr);
        bus(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, addr, 32'h0, 1'b1);
    endtask

    task automatic port(input string tag, input logic wren, input logic [3:0] ben,
                        input logic [ADDR_W-1:0] addr, input logic [31:0] din);
        check({tag, "_wren"}, {31'h0, sram_wren}, {31'h0, wren});
        check({tag, "_ben"},  {28'h0, sram_ben},  {28'h0, ben});
        check({tag, "_addr"}, {24'h0, sram_addr}, {24'h0, addr});
        check({tag, "_din"},  sram_din, din);
    endtask

    initial begin
        logic [31:0] old_word;

        // Reset values.
        @(negedge clk);
        port("rst", 1'b0, 4'b0000, 8'h00, 32'h0);
        check("rst_hrdata", hrdata, 32'h0);
        check("rst_resp", {30'h0, hreadyout, hresp}, 32'h2);
        rst_n = 1'b1;

        // Word write then idle: commit in the data phase straight from hwdata.
        wr_op(10'h010, HSIZE_WORD, 32'hDEADBEEF);
        idle(); #1 port("t1", 1'b1, 4'b1111, 8'h04, 32'hDEADBEEF);
        rd_op(10'h010);
        idle();

        // Write then immediate read of the same word: commit deferred, data forwarded.
        wr_op(10'h020, HSIZE_WORD, 32'h11223344);
        rd_op(10'h020); #1 check("t2_defer", {31'h0, sram_wren}, 32'h0);
        idle(); #1 port("t2_commit", 1'b1, 4'b1111, 8'h08, 32'h11223344);

        // Byte write to lane 3 followed immediately by a read.
        wr_op(10'h020, HSIZE_WORD, 32'h0);
        idle();
        wr_op(10'h023, HSIZE_BYTE, 32'hAA000000);
        rd_op(10'h020); #1 check("t3_defer", {31'h0, sram_wren}, 32'h0);
        idle(); #1 port("t3_fwd", 1'b1, 4'b1000, 8'h08, 32'hAA000000);

        // Byte write with an idle in between; other lanes of hwdata must be masked.
        wr_op(10'h020, HSIZE_WORD, 32'h0);
        idle();
        wr_op(10'h023, HSIZE_BYTE, 32'hAA123456);
        idle(); #1 port("t3_idle", 1'b1, 4'b1000, 8'h08, 32'hAA123456);
        rd_op(10'h020);
        idle();

        // Back-to-back halfword writes commit in consecutive cycles.
        wr_op(10'h032, HSIZE_HALF, 32'hBEEF0000);
        wr_op(10'h030, HSIZE_HALF, 32'h0000CAFE); #1 port("t4_hi", 1'b1, 4'b1100, 8'h0C, 32'hBEEF0000);
        idle(); #1 port("t4_lo", 1'b1, 4'b0011, 8'h0C, 32'h0000CAFE);
        rd_op(10'h030);
        idle();

        // Reads of another word starve the commit; exactly one commit afterwards.
        wr_op(10'h040, HSIZE_WORD, 32'h5A5A0F0F);
        for (int i = 0; i < 5; i++) begin
            rd_op(10'h044); #1 check("t5_starve", {31'h0, sram_wren}, 32'h0);
        end
        idle(); #1 port("t5_commit", 1'b1, 4'b1111, 8'h10, 32'h5A5A0F0F);
        idle(); #1 check("t5_once", {31'h0, sram_wren}, 32'h0);

        // Reset during a write's data phase discards the write.
        old_word = ref_word(10'h050);
        wr_op(10'h050, HSIZE_WORD, 32'hCAFEF00D);
        idle();
        #1 rst_n = 1'b0;
        #1 port("t6_rst", 1'b0, 4'b0000, 8'h00, 32'h0);
        check("t6_hrdata", hrdata, 32'h0);
        ref_write(10'h050, HSIZE_WORD, old_word);
        dph_wr = 1'b0;
        exp_rd_v = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("t6_mem", mem[8'h14], old_word);
        rd_op(10'h050);
        idle();

        // Random traffic over a small window so reads often hit the buffer.
        for (int i = 0; i < 400; i++) begin
            bus($urandom_range(0, 7) != 0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                3'($urandom_range(0, 3)), int'($urandom_range(0, 63)), $urandom(),
                $urandom_range(0, 9) != 0);
        end
        repeat (3) idle();
        @(posedge clk); #1;
        for (int w = 0; w < 32; w++) check("mem_final", mem[w], ref_word(w * 4));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
